input_debounce: RTL and testbench
=================================

Name: input_debounce

Overview:
- Conditions the 16 raw field inputs of the PLC before they reach the CPU input bus `WE[15:0]`, which the DMA channel samples into image memory.
- Per channel: 2-FF synchronizer, then a tick-based debounce filter with programmable length.
- Output word can be frozen for the duration of an image scan.
- Sticky change flags allow later interrupt or event use.

Parameters:
- `N_CH`, 16, number of input channels.
- `CNT_W`, 4, width of per-channel debounce counter and `FILT_LEN`.
- `PRESC_DIV`, 1000, filter tick period in `CLK` cycles (≥1).
- `PRESC_W`, 16, prescaler counter width; must hold `PRESC_DIV-1`.

Ports:
- `CLK`  in  1  system clock.
- `CLR`  in  1  synchronous active-low reset.
- `RUN`  in  1  filter enable; low = prescaler and counters held at 0.
- `IN_RAW`  in  `N_CH`  asynchronous field inputs.
- `FILT_LEN`  in  `CNT_W`  required number of consecutive stable ticks; 0 treated as 1.
- `FREEZE`  in  1  high = `WE` holds its value (driven during DMA input scan).
- `ACK`  in  1  clears all `CHG` flags.
- `WE`  out  `N_CH`  debounced, registered input word to the CPU.
- `CHG`  out  `N_CH`  sticky per-channel "accepted change" flags.
- `TICK`  out  1  one-cycle filter tick strobe.

Behaviour:
- Reset (`CLR`=0 at a `CLK` edge) clears:
  - sync stages `s1` and `s2`, stable register, counters, prescaler;
  - outputs `WE`=0, `CHG`=0, `TICK`=0.
  - Reset mid-filtering discards partial counts.
- Prescaler:
  - With `RUN`=1, counts 0..`PRESC_DIV-1` and wraps.
  - `TICK`=1 for exactly the cycle in which the count equals `PRESC_DIV-1`.
  - `PRESC_DIV`=1 gives `TICK` every cycle.
  - With `RUN`=0, the prescaler is forced to 0 and `TICK`=0.
- Synchronizer: `s1`<=`IN_RAW`, `s2`<=`s1`, every cycle regardless of `RUN`.
- Per-channel filter, evaluated every cycle:
  - `s2`==stable: counter<=0.
  - `s2`!=stable and `TICK`: if counter+1 >= max(`FILT_LEN`,1), then stable<=`s2`, counter<=0, `CHG` bit set. Otherwise counter<=counter+1.
  - `s2`!=stable and no `TICK`: hold.
  - `RUN`=0: counter<=0, stable held.
- Glitch shorter than L ticks: counter returns to 0, no change accepted.
- Counter never exceeds L-1, so no wrap. A `FILT_LEN` change takes effect on the next compare.
- Latency, with `PRESC_DIV`=1 and L=`FILT_LEN`: a raw change captured by `s1` at edge k is accepted into stable at edge k+1+L. `WE` updates at edge k+2+L if `FREEZE`=0.
- `WE`: registered. `WE`<=stable when `FREEZE`=0; holds when `FREEZE`=1. Acceptances during freeze appear on the first cycle after `FREEZE` falls.
- `CHG`:
  - `ACK` clears all bits.
  - A set and an `ACK` in the same cycle on one bit: set wins.
  - Unaffected by `FREEZE`.

Optional Feature:
- Macro `PULSE_CATCH_EN`.
- Defined:
  - A per-channel latch is set by any rising edge of `s2` (`s2` & ~`s2_prev`), even one rejected by the filter.
  - `WE` loads stable | latch when `FREEZE`=0.
  - Latch clears on the cycle after `FREEZE` falls (end of scan), unless a new rising edge occurs in that same cycle.
  - Guarantees a short pulse is seen by at least one scan.
- Undefined: no latch logic; `WE` loads stable only.

Decomposition:
- Shared package `plc_io_pkg`: `N_CH`, `CNT_W`, default `PRESC_DIV`, and `FILT_LEN` default constant 4.
- Sub-module `debounce_channel` (sync + counter + stable + `CHG` bit, optional latch), instantiated `N_CH` times by generate.
- Prescaler, `WE` register and `FREEZE` edge detect stay in the top.

Test Plan:
- Reset: `CLR`=0 for 2 cycles with `IN_RAW`=16'hFFFF. `WE`, `CHG` and `TICK` stay 0 during reset. `WE`=16'hFFFF exactly 2+L+1 cycles after `CLR` rises.
- Latency (`PRESC_DIV`=1, `FILT_LEN`=4): `IN_RAW[3]` 0->1 before edge k. `WE[3]`=1 at edge k+6, not earlier; `CHG[3]` set at edge k+5.
- Glitch (`FILT_LEN`=4): `IN_RAW[0]` high for 3 ticks, then low. `WE[0]` stays 0, `CHG[0]` stays 0. Repeat with 4 ticks and `WE[0]` goes to 1.
- Freeze: `FREEZE`=1, then channel 5 is accepted. `WE` is unchanged while frozen. `WE[5]`=1 one cycle after `FREEZE` falls.
- `CHG`/`ACK` collision: `ACK`=1 in the same cycle as channel 2 acceptance. `CHG[2]`=1 afterwards, while other set bits clear.
- `PULSE_CATCH_EN`: a 2-cycle pulse on `IN_RAW[7]` with `FILT_LEN`=4. `WE[7]`=1 until the cycle after the next `FREEZE` falling edge, then 0. Without the macro, `WE[7]` never rises.

Source files
------------

// File: rtl/plc_io_pkg.sv
// Shared constants and helpers for the PLC field-input conditioning path.
// Channel count, counter width and default filter settings live here.
package plc_io_pkg;

    localparam int N_CH          = 16;
    localparam int CNT_W         = 4;
    localparam int PRESC_DIV_DEF = 1000;
    localparam int PRESC_W_DEF   = 16;

    localparam logic [CNT_W-1:0] FILT_LEN_DEF = CNT_W'(4);

    // A programmed length of zero behaves as a single-tick filter.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        return (len == '0) ? CNT_W'(1) : len;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-FF synchronizer, tick-based debounce counter,
// stable value and sticky change flag. PULSE_CATCH_EN adds a rising-edge latch.
module debounce_channel
    import plc_io_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic             tick,
    input  logic             raw,
    input  logic [CNT_W-1:0] len,
    input  logic             ack,
`ifdef PULSE_CATCH_EN
    input  logic             scan_end,
`endif
    output logic             word,
    output logic             chg
);

    logic             s1;
    logic             s2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             hit;

    assign hit = ({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, len};

    // Bring the asynchronous field input into the clock domain.
    always_ff @(posedge clk) begin
        if (!clr) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Count consecutive differing ticks; accept once the run reaches len.
    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt    <= '0;
            stable <= 1'b0;
            chg    <= 1'b0;
        end else begin
            chg <= chg & ~ack;
            if (!run || (s2 == stable)) begin
                cnt <= '0;
            end else if (tick) begin
                if (hit) begin
                    stable <= s2;
                    cnt    <= '0;
                    chg    <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef PULSE_CATCH_EN
    logic s2_prev;
    logic latch;

    // Remember any rising edge until the end of the next image scan.
    always_ff @(posedge clk) begin
        if (!clr) begin
            s2_prev <= 1'b0;
            latch   <= 1'b0;
        end else begin
            s2_prev <= s2;
            latch   <= (s2 & ~s2_prev) | (latch & ~scan_end);
        end
    end

    assign word = stable | latch;
`else
    assign word = stable;
`endif

endmodule

// File: rtl/input_debounce.sv
// PLC input conditioning: prescaler, N_CH debounce channels, WE word register.
// Optional macro PULSE_CATCH_EN enables per-channel short-pulse latches.
module input_debounce
    import plc_io_pkg::*;
#(
    parameter int PRESC_DIV = PRESC_DIV_DEF,
    parameter int PRESC_W   = PRESC_W_DEF
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             RUN,
    input  logic [N_CH-1:0]  IN_RAW,
    input  logic [CNT_W-1:0] FILT_LEN,
    input  logic             FREEZE,
    input  logic             ACK,
    output logic [N_CH-1:0]  WE,
    output logic [N_CH-1:0]  CHG,
    output logic             TICK
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESC_DIV - 1);

    logic [PRESC_W-1:0] presc;
    logic [CNT_W-1:0]   len;
    logic [N_CH-1:0]    word;

    assign len  = eff_len(FILT_LEN);
    assign TICK = CLR & RUN & (presc == LAST);

    // Free-running tick prescaler, parked at zero while the filter is idle.
    always_ff @(posedge CLK) begin
        if (!CLR || !RUN || (presc == LAST)) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

`ifdef PULSE_CATCH_EN
    logic freeze_q;
    logic scan_end;

    assign scan_end = freeze_q & ~FREEZE;

    // Track FREEZE to find the end of each image scan.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            freeze_q <= 1'b0;
        end else begin
            freeze_q <= FREEZE;
        end
    end
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel u_ch (
            .clk      (CLK),
            .clr      (CLR),
            .run      (RUN),
            .tick     (TICK),
            .raw      (IN_RAW[i]),
            .len      (len),
            .ack      (ACK),
`ifdef PULSE_CATCH_EN
            .scan_end (scan_end),
`endif
            .word     (word[i]),
            .chg      (CHG[i])
        );
    end

    // Present the filtered word to the CPU; hold it steady during a scan.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            WE <= '0;
        end else if (!FREEZE) begin
            WE <= word;
        end
    end

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce with a history-window reference model.
// Expectations adapt when PULSE_CATCH_EN is defined.
module tb_input_debounce;
    import plc_io_pkg::*;

`ifdef PULSE_CATCH_EN
    localparam bit PC      = 1'b1;
    localparam int WE_RISE = 4;
`else
    localparam bit PC      = 1'b0;
    localparam int WE_RISE = 7;
`endif

    logic             CLK = 1'b0;
    logic             CLR;
    logic             RUN;
    logic [N_CH-1:0]  IN_RAW;
    logic [CNT_W-1:0] FILT_LEN;
    logic             FREEZE;
    logic             ACK;
    logic [N_CH-1:0]  WE;
    logic [N_CH-1:0]  CHG;
    logic             TICK;

    always #5 CLK = ~CLK;

    input_debounce #(
        .PRESC_DIV (1),
        .PRESC_W   (16)
    ) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .RUN      (RUN),
        .IN_RAW   (IN_RAW),
        .FILT_LEN (FILT_LEN),
        .FREEZE   (FREEZE),
        .ACK      (ACK),
        .WE       (WE),
        .CHG      (CHG),
        .TICK     (TICK)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: every clock edge is logged; an input is accepted
    // when the synchronized value (raw delayed by two edges) has differed
    // from the stable value on the last L running ticks.
    typedef struct {
        logic [15:0] raw;
        bit          run;
        bit          clr;
        bit          frz;
    } ent_t;

    ent_t        h[$];
    logic [15:0] m_stable = '0;
    logic [15:0] m_we     = '0;
    logic [15:0] m_chg    = '0;
    logic [15:0] m_latch  = '0;

    function automatic logic [15:0] s2_at(int i);
        if (i < 2) return '0;
        if (!h[i-1].clr || !h[i-2].clr) return '0;
        return h[i-2].raw;
    endfunction

    function automatic void model_step();
        int          n;
        int          l;
        int          idx;
        bit          ok;
        logic [15:0] v;
        logic [15:0] acc;
        logic [15:0] prev;
        logic [15:0] rise;
        logic [15:0] lt;
        bit          fall;
        h.push_back('{IN_RAW, RUN, CLR, FREEZE});
        n = h.size() - 1;
        if (!CLR) begin
            m_stable = '0;
            m_we     = '0;
            m_chg    = '0;
            m_latch  = '0;
            return;
        end
        l   = (FILT_LEN == 0) ? 1 : int'(FILT_LEN);
        acc = '0;
        for (int c = 0; c < N_CH; c++) begin
            ok = 1'b1;
            for (int j = 0; j < l; j++) begin
                idx = n - j;
                if (idx < 0) ok = 1'b0;
                else if (!h[idx].run || !h[idx].clr) ok = 1'b0;
                else begin
                    v = s2_at(idx);
                    if (v[c] === m_stable[c]) ok = 1'b0;
                end
            end
            acc[c] = ok;
        end
        prev = (n >= 1 && h[n-1].clr) ? s2_at(n-1) : '0;
        rise = s2_at(n) & ~prev;
        fall = (n >= 1) && h[n-1].clr && h[n-1].frz && !FREEZE;
        lt   = PC ? m_latch : '0;
        if (!FREEZE) m_we = m_stable | lt;
        m_chg    = acc | (m_chg & ~{16{ACK}});
        m_latch  = rise | (m_latch & ~{16{fall}});
        m_stable = m_stable ^ acc;
    endfunction

    task automatic cyc();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic settle(input logic [15:0] v);
        IN_RAW   = v;
        FREEZE   = 1'b0;
        ACK      = 1'b0;
        RUN      = 1'b1;
        FILT_LEN = FILT_LEN_DEF;
        repeat (10) cyc();
        FREEZE = 1'b1;
        cyc();
        FREEZE = 1'b0;
        ACK    = 1'b1;
        cyc();
        ACK = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        CLR      = 1'b0;
        RUN      = 1'b1;
        IN_RAW   = 16'hFFFF;
        FILT_LEN = FILT_LEN_DEF;
        FREEZE   = 1'b0;
        ACK      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if ({WE, CHG, TICK} !== 33'b0) begin
                errors++;
                $display("FAIL reset_hold we=%h chg=%h tick=%b exp 0", WE, CHG, TICK);
            end
        end
        CLR = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            checks++;
            if (WE !== ((i >= WE_RISE) ? 16'hFFFF : 16'h0000)) begin
                errors++;
                $display("FAIL reset_we cyc=%0d got %h", i, WE);
            end
            checks++;
            if (CHG !== ((i >= 6) ? 16'hFFFF : 16'h0000)) begin
                errors++;
                $display("FAIL reset_chg cyc=%0d got %h", i, CHG);
            end
            checks++;
            if (TICK !== 1'b1) begin
                errors++;
                $display("FAIL reset_tick cyc=%0d got %b exp 1", i, TICK);
            end
        end
    endtask

    task automatic test_latency();
        settle(16'h0000);
        IN_RAW = 16'h0008;
        for (int j = 1; j <= 9; j++) begin
            cyc();
            checks++;
            if (WE[3] !== (j >= WE_RISE)) begin
                errors++;
                $display("FAIL lat_we3 edge=k+%0d got %b exp %b", j - 1, WE[3], j >= WE_RISE);
            end
            checks++;
            if (CHG[3] !== (j >= 6)) begin
                errors++;
                $display("FAIL lat_chg3 edge=k+%0d got %b exp %b", j - 1, CHG[3], j >= 6);
            end
            checks++;
            if ({WE, CHG} !== {m_we, m_chg}) begin
                errors++;
                $display("FAIL lat_model we=%h/%h chg=%h/%h", WE, m_we, CHG, m_chg);
            end
        end
    endtask

    task automatic test_glitch();
        settle(16'h0000);
        IN_RAW = 16'h0001;
        for (int j = 1; j <= 13; j++) begin
            if (j == 4) IN_RAW = 16'h0000;
            cyc();
            checks++;
            if (CHG[0] !== 1'b0) begin
                errors++;
                $display("FAIL glitch3_chg0 cyc=%0d got %b exp 0", j, CHG[0]);
            end
`ifndef PULSE_CATCH_EN
            checks++;
            if (WE[0] !== 1'b0) begin
                errors++;
                $display("FAIL glitch3_we0 cyc=%0d got %b exp 0", j, WE[0]);
            end
`endif
        end
        settle(16'h0000);
        IN_RAW = 16'h0001;
        for (int j = 1; j <= 8; j++) begin
            if (j == 5) IN_RAW = 16'h0000;
            cyc();
            if (j == 7) begin
                checks++;
                if ({WE[0], CHG[0]} !== 2'b11) begin
                    errors++;
                    $display("FAIL glitch4_acc we0=%b chg0=%b exp 11", WE[0], CHG[0]);
                end
            end
            checks++;
            if ({WE, CHG} !== {m_we, m_chg}) begin
                errors++;
                $display("FAIL glitch4_model we=%h/%h chg=%h/%h", WE, m_we, CHG, m_chg);
            end
        end
    endtask

    task automatic test_freeze();
        settle(16'h0000);
        FREEZE = 1'b1;
        IN_RAW = 16'h0020;
        for (int j = 1; j <= 12; j++) begin
            cyc();
            checks++;
            if (WE !== 16'h0000) begin
                errors++;
                $display("FAIL frz_hold cyc=%0d got %h exp 0000", j, WE);
            end
        end
        checks++;
        if (CHG !== 16'h0020) begin
            errors++;
            $display("FAIL frz_chg got %h exp 0020", CHG);
        end
        FREEZE = 1'b0;
        cyc();
        checks++;
        if (WE !== 16'h0020) begin
            errors++;
            $display("FAIL frz_release got %h exp 0020", WE);
        end
    endtask

    task automatic test_ack_collision();
        settle(16'h0000);
        IN_RAW = 16'h0002;
        repeat (8) cyc();
        IN_RAW = 16'h0006;
        for (int j = 1; j <= 7; j++) begin
            ACK = (j == 6);
            cyc();
            if (j == 5) begin
                checks++;
                if (CHG !== 16'h0002) begin
                    errors++;
                    $display("FAIL ack_pre got %h exp 0002", CHG);
                end
            end
            if (j >= 6) begin
                checks++;
                if (CHG !== 16'h0004) begin
                    errors++;
                    $display("FAIL ack_collide cyc=%0d got %h exp 0004", j, CHG);
                end
            end
        end
        ACK = 1'b0;
    endtask

    task automatic test_pulse_catch();
        settle(16'h0000);
        IN_RAW = 16'h0080;
        for (int j = 1; j <= 10; j++) begin
            if (j == 3) IN_RAW = 16'h0000;
            cyc();
            checks++;
            if (WE[7] !== (PC && j >= 4)) begin
                errors++;
                $display("FAIL pulse_we7 cyc=%0d got %b exp %b", j, WE[7], PC && j >= 4);
            end
            checks++;
            if (CHG[7] !== 1'b0) begin
                errors++;
                $display("FAIL pulse_chg7 cyc=%0d got %b exp 0", j, CHG[7]);
            end
        end
        FREEZE = 1'b1;
        repeat (3) cyc();
        checks++;
        if (WE[7] !== PC) begin
            errors++;
            $display("FAIL pulse_frz got %b exp %b", WE[7], PC);
        end
        FREEZE = 1'b0;
        cyc();
        checks++;
        if (WE[7] !== PC) begin
            errors++;
            $display("FAIL pulse_scan_end got %b exp %b", WE[7], PC);
        end
        cyc();
        checks++;
        if (WE[7] !== 1'b0) begin
            errors++;
            $display("FAIL pulse_cleared got %b exp 0", WE[7]);
        end
    endtask

    task automatic test_run_gate();
        settle(16'h0000);
        RUN    = 1'b0;
        IN_RAW = 16'h0100;
        for (int j = 1; j <= 12; j++) begin
            cyc();
            checks++;
            if ({TICK, CHG[8]} !== 2'b00) begin
                errors++;
                $display("FAIL run_off tick=%b chg8=%b exp 00", TICK, CHG[8]);
            end
        end
        RUN = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            cyc();
            checks++;
            if (CHG[8] !== (j >= 4)) begin
                errors++;
                $display("FAIL run_on_chg8 cyc=%0d got %b exp %b", j, CHG[8], j >= 4);
            end
        end
    endtask

    task automatic test_random();
        int dur;
        settle(16'h0000);
        for (int s = 0; s < 400; s++) begin
            IN_RAW = IN_RAW ^ (16'($urandom) & 16'($urandom));
            if ($urandom_range(0, 7) == 0) FILT_LEN = CNT_W'($urandom_range(0, 5));
            FREEZE = ($urandom_range(0, 4) == 0);
            RUN    = ($urandom_range(0, 9) != 0);
            dur    = $urandom_range(1, 7);
            for (int d = 0; d < dur; d++) begin
                ACK = ($urandom_range(0, 5) == 0);
                cyc();
                checks++;
                if ({WE, CHG, TICK} !== {m_we, m_chg, RUN & CLR}) begin
                    errors++;
                    $display("FAIL rand_model seg=%0d we=%h/%h chg=%h/%h tick=%b/%b",
                             s, WE, m_we, CHG, m_chg, TICK, RUN & CLR);
                end
            end
        end
        ACK    = 1'b0;
        FREEZE = 1'b0;
        RUN    = 1'b1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_freeze();
        test_ack_collision();
        test_pulse_catch();
        test_run_gate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
